// File: rtl/usr_seq_if.sv
// usr_seq_if: operator inputs and USR drive outputs of the shift/load sequencer
interface usr_seq_if #(
  parameter int WIDTH = 8,
  parameter int SW = 2
);
  logic i_exe;
  logic [SW-1:0] i_slide;
  logic [2:0] o_s;
  logic [WIDTH-1:0] o_l;
  logic o_busy;
  logic [2:0] o_stage;
  logic o_done;
  modport master (output i_exe, i_slide, input o_s, o_l, o_busy, o_stage, o_done);
  modport slave (input i_exe, i_slide, output o_s, o_l, o_busy, o_stage, o_done);
endinterface

// File: rtl/usr_seq_control.sv
// usr_seq_control: exe/slide command entry driving a universal shift register with shift or load sequences.
// USR_SEQ_DEBOUNCE_EN adds a synchroniser and DEB_CYCLES debouncer on exe.
module usr_seq_control #(
  parameter int WIDTH = 8,
  parameter int SW = 2
`ifdef USR_SEQ_DEBOUNCE_EN
  , parameter int DEB_CYCLES = 16
`endif
) (
  input logic clk,
  input logic reset,
  usr_seq_if.slave bus
);
  localparam int N = WIDTH / SW;
  localparam int CW = $clog2(WIDTH);
  localparam int KW = $clog2(N + 1);
  typedef enum logic [2:0] {IDLE, MODE, AMT, RUN, LOAD, LOAD_ISSUE, DONE} state_t;
  state_t r_state, w_nx;
  logic r_dir, w_dir;
  logic [1:0] r_mode, w_mode;
  logic [CW-1:0] r_cnt, w_cnt, w_amt;
  logic [KW-1:0] r_k, w_k;
  logic [WIDTH-1:0] r_asm, w_asm, r_l, w_l;
  logic [2:0] r_s, w_s, r_stage, w_stage, w_code;
  logic r_busy, r_done, w_lvl, w_prev, w_step;
`ifdef USR_SEQ_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  logic [1:0] r_sync;
  logic r_deb, r_deb_q;
  logic [DW-1:0] r_dcnt;
  // level flips only after DEB_CYCLES consecutive samples disagreeing with it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= 2'b11;
      r_deb <= 1'b1;
      r_deb_q <= 1'b1;
      r_dcnt <= '0;
    end else begin
      r_sync <= {r_sync[0], bus.i_exe};
      r_deb_q <= r_deb;
      if (r_sync[1] == r_deb) r_dcnt <= '0;
      else if (r_dcnt == DW'(DEB_CYCLES - 1)) begin
        r_deb <= r_sync[1];
        r_dcnt <= '0;
      end else r_dcnt <= r_dcnt + 1'b1;
    end
  end
  assign w_lvl = r_deb;
  assign w_prev = r_deb_q;
`else
  logic r_exe_q;
  always_ff @(posedge clk) r_exe_q <= reset ? 1'b1 : bus.i_exe;
  assign w_lvl = bus.i_exe;
  assign w_prev = r_exe_q;
`endif
  assign w_step = w_lvl & ~w_prev;
  assign w_amt = (32'(bus.i_slide) >= WIDTH) ? CW'(WIDTH - 1) : CW'(bus.i_slide);
  assign w_code = w_dir ? {w_mode, 1'b0} : {w_mode - 2'd1, 1'b1};
  always_comb begin
    w_nx = r_state;
    w_dir = r_dir;
    w_mode = r_mode;
    w_cnt = r_cnt;
    w_k = r_k;
    w_asm = r_asm;
    case (r_state)
      IDLE: if (w_step) begin
        if (bus.i_slide == SW'(1) || bus.i_slide == SW'(2)) begin
          w_nx = MODE;
          w_dir = bus.i_slide == SW'(2);
        end else if (bus.i_slide == SW'(3)) begin
          w_nx = LOAD;
          w_k = '0;
          w_asm = '0;
        end
      end
      MODE: if (w_step) begin
        w_nx = (bus.i_slide == '0) ? IDLE : AMT;
        w_mode = 2'(bus.i_slide);
      end
      AMT: if (w_step) begin
        w_nx = (w_amt == '0) ? DONE : RUN;
        w_cnt = w_amt;
      end
      RUN: begin
        w_cnt = r_cnt - 1'b1;
        w_nx = (r_cnt == CW'(1)) ? DONE : RUN;
      end
      LOAD: if (w_step) begin
        w_asm = WIDTH'({r_asm, bus.i_slide});
        w_k = r_k + 1'b1;
        w_nx = (r_k == KW'(N - 1)) ? LOAD_ISSUE : LOAD;
      end
      LOAD_ISSUE: w_nx = DONE;
      default: w_nx = IDLE;
    endcase
  end
  // outputs are registered from the next state so they align with it
  assign w_s = (w_nx == RUN) ? w_code : (w_nx == LOAD_ISSUE) ? 3'b111 : 3'b000;
  assign w_l = (w_nx == LOAD_ISSUE) ? w_asm : r_l;
  assign w_stage = (w_nx == IDLE) ? 3'd0 : (w_nx == MODE) ? 3'd1 : (w_nx == AMT) ? 3'd2 :
                   (w_nx == LOAD) ? 3'd3 : 3'd4;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_dir <= 1'b0;
      r_mode <= '0;
      r_cnt <= '0;
      r_k <= '0;
      r_asm <= '0;
      r_s <= '0;
      r_l <= '0;
      r_stage <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_nx;
      r_dir <= w_dir;
      r_mode <= w_mode;
      r_cnt <= w_cnt;
      r_k <= w_k;
      r_asm <= w_asm;
      r_s <= w_s;
      r_l <= w_l;
      r_stage <= w_stage;
      r_busy <= w_nx inside {RUN, LOAD_ISSUE, DONE};
      r_done <= w_nx == DONE;
    end
  end
  assign bus.o_s = r_s;
  assign bus.o_l = r_l;
  assign bus.o_stage = r_stage;
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
endmodule

// File: tb/tb_usr_seq_control.sv
// tb_usr_seq_control: directed command steps on WIDTH=8 and WIDTH=2 sequencers with a per-cycle expected-trace queue
module tb_usr_seq_control;
  typedef struct packed {
    logic [2:0] s;
    logic [7:0] l;
    logic busy;
    logic done;
    logic [2:0] stage;
  } exp_t;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  logic [7:0] l8 = 0;
  usr_seq_if #(.WIDTH(8), .SW(2)) b8();
  usr_seq_if #(.WIDTH(2), .SW(2)) b2();
  usr_seq_control #(.WIDTH(8), .SW(2)) u8 (.clk(clk), .reset(reset), .bus(b8.slave));
  usr_seq_control #(.WIDTH(2), .SW(2)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));
  always #5 clk = ~clk;
  function automatic exp_t obs(input bit sel);
    return sel ? exp_t'({b2.o_s, 6'd0, b2.o_l, b2.o_busy, b2.o_done, b2.o_stage})
               : exp_t'({b8.o_s, b8.o_l, b8.o_busy, b8.o_done, b8.o_stage});
  endfunction
  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic step(input bit sel, input logic [1:0] v);
    @(negedge clk);
    if (sel) b2.i_exe = 0; else b8.i_exe = 0;
    @(negedge clk);
    if (sel) begin b2.i_exe = 1; b2.i_slide = v; end
    else begin b8.i_exe = 1; b8.i_slide = v; end
  endtask
  task automatic stage_is(input bit sel, input string tag, input logic [2:0] st);
    exp_t o;
    @(negedge clk);
    o = obs(sel);
    chk(tag, 16'(o.stage), 16'(st));
  endtask
  task automatic push_shift(input logic [2:0] code, input int amt, input logic [7:0] l);
    for (int i = 0; i < amt; i++) sb.push_back({code, l, 1'b1, 1'b0, 3'd4});
    sb.push_back({3'b000, l, 1'b1, 1'b1, 3'd4});
    sb.push_back({3'b000, l, 1'b0, 1'b0, 3'd0});
  endtask
  task automatic push_load(input logic [7:0] l);
    sb.push_back({3'b111, l, 1'b1, 1'b0, 3'd4});
    sb.push_back({3'b000, l, 1'b1, 1'b1, 3'd4});
    sb.push_back({3'b000, l, 1'b0, 1'b0, 3'd0});
  endtask
  task automatic drain(input bit sel, input bit tog, input string tag);
    exp_t e, o;
    int n = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      o = obs(sel);
      chk($sformatf("%s[%0d]", tag, n), o, e);
      n++;
      if (tog) begin
        b8.i_slide = 0;
        b8.i_exe = ~b8.i_exe;
      end
    end
    b8.i_exe = 1;
  endtask
  initial begin
    exp_t o;
    b8.i_exe = 1; b8.i_slide = 0;
    b2.i_exe = 1; b2.i_slide = 0;
    repeat (3) @(negedge clk);
    chk("reset_w8", obs(0), 16'h0);
    chk("reset_w2", obs(1), 16'h0);
    reset = 0;
`ifdef USR_SEQ_DEBOUNCE_EN
    b8.i_slide = 2'b01;
    b8.i_exe = 0;
    repeat (3) @(negedge clk);
    b8.i_exe = 1;
    repeat (40) @(negedge clk);
    o = obs(0);
    chk("deb_glitch_stage", 16'(o.stage), 16'd0);
    b8.i_exe = 0;
    repeat (20) @(negedge clk);
    b8.i_exe = 1;
    repeat (40) @(negedge clk);
    o = obs(0);
    chk("deb_step_stage", 16'(o.stage), 16'd1);
    chk("deb_step_busy", 16'(o.busy), 16'd0);
`else
    step(0, 2'b01); stage_is(0, "rl3_stage_mode", 3'd1);
    step(0, 2'b10); stage_is(0, "rl3_stage_amt", 3'd2);
    step(0, 2'd3);
    push_shift(3'b011, 3, l8);
    drain(0, 0, "shift_r_log3");
    step(0, 2'b10); step(0, 2'b11); step(0, 2'd0);
    push_shift(3'b110, 0, l8);
    drain(0, 0, "shift_amt0");
    step(0, 2'b11); stage_is(0, "load_stage", 3'd3);
    step(0, 2'b10); step(0, 2'b01); step(0, 2'b11); step(0, 2'b00);
    l8 = 8'h9C;
    push_load(l8);
    drain(0, 0, "load_9c");
    step(1, 2'b01); step(1, 2'b01); step(1, 2'd3);
    push_shift(3'b001, 1, 8'h00);
    drain(1, 0, "w2_clamp");
    step(0, 2'b01); step(0, 2'b01); step(0, 2'd3);
    push_shift(3'b001, 3, l8);
    drain(0, 1, "toggle_run");
    stage_is(0, "toggle_idle_stage", 3'd0);
    step(0, 2'b01); step(0, 2'b00);
    repeat (3) sb.push_back({3'b000, l8, 1'b0, 1'b0, 3'd0});
    drain(0, 0, "mode_abort");
    step(0, 2'b10); step(0, 2'b10); step(0, 2'd3);
    @(negedge clk);
    chk("rst_run_c1", obs(0), {3'b100, l8, 1'b1, 1'b0, 3'd4});
    @(negedge clk);
    chk("rst_run_c2", obs(0), {3'b100, l8, 1'b1, 1'b0, 3'd4});
    reset = 1;
    @(negedge clk);
    chk("rst_run_abort", obs(0), 16'h0);
    reset = 0;
    l8 = 0;
    @(negedge clk);
    chk("rst_run_quiet", obs(0), 16'h0);
    step(0, 2'b10); step(0, 2'b01); step(0, 2'd2);
    push_shift(3'b010, 2, l8);
    drain(0, 0, "fresh_after_rst");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
